// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared defaults, length helper and state type for seq_detect_prog
package seq_detect_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int CNT_W_DEF = 16;
    localparam int MIN_LEN   = 2;

    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } det_state_e;

    function automatic int len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_match_cmp.sv
// rtl/seq_match_cmp.sv - combinational compare of the low len bits of a history word against a pattern
module seq_match_cmp #(
    parameter int W     = 9,
    parameter int LEN_W = 4
) (
    input  logic [W-1:0]     hist,
    input  logic [W-1:0]     pat,
    input  logic [LEN_W-1:0] len,
    output logic             hit
);

    logic [W-1:0] mask;

    always_comb begin
        mask = '0;
        for (int i = 0; i < W; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    assign hit = (((hist ^ pat) & mask) == '0);

endmodule

// File: rtl/seq_detect_prog.sv
// rtl/seq_detect_prog.sv - programmable serial pattern detector with overlap control and saturating match count
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter  int PAT_W = PAT_W_DEF,
    parameter  int CNT_W = CNT_W_DEF,
    localparam int LEN_W = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inp_bit,
    input  logic             inp_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic [LEN_W-1:0] len_in,
    input  logic             overlap_en,
    input  logic             clear_count,
    output logic             seq_seen,
    output logic [CNT_W-1:0] match_count,
    output logic             cfg_err
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(MIN_LEN);

    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d, next_fill;
    logic [CNT_W-1:0] count_d;
    logic [PAT_W:0]   hist_ext;
    logic             hit, match;
    det_state_e       state;

    // Compare one bit wider than the history: the bit shifted out is always masked off.
    assign hist_ext  = {hist_q, inp_bit};
    assign next_fill = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + LEN_W'(1);

    seq_match_cmp #(
        .W     (PAT_W + 1),
        .LEN_W (LEN_W)
    ) u_cmp (
        .hist (hist_ext),
        .pat  ({1'b0, pat_q}),
        .len  (len_q),
        .hit  (hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q       <= '0;
            len_q       <= '0;
            cfg_err     <= 1'b1;
            hist_q      <= '0;
            fill_q      <= '0;
            seq_seen    <= 1'b0;
            match_count <= '0;
        end else begin
            if (cfg_load) begin
                pat_q   <= pattern_in;
                len_q   <= len_in;
                cfg_err <= (len_in < LEN_MIN) || (len_in > FILL_MAX);
            end
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            seq_seen    <= match;
            match_count <= count_d;
        end
    end

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        match   = 1'b0;
        count_d = match_count;
        state   = (next_fill >= len_q) ? ARMED : FILLING;

        if (cfg_load) begin
            hist_d = '0;
            fill_d = '0;
        end else if (inp_valid) begin
            hist_d = hist_ext[PAT_W-1:0];
            fill_d = next_fill;
            match  = !cfg_err && (state == ARMED) && hit;
            if (match && !overlap_en) begin
                fill_d = '0;
            end
        end

        if (clear_count) begin
            count_d = '0;
        end else if (match && (match_count != '1)) begin
            count_d = match_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/seq_detect_prog.md
SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

Interface
REQ-001 Parameter PAT_W, default 8: maximum pattern length in bits, legal range 2..32.
REQ-002 Parameter CNT_W, default 16: match counter width.
REQ-003 Derived constant LEN_W = $clog2(PAT_W+1).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 inp_bit  input  1  serial data bit.
REQ-007 inp_valid  input  1  inp_bit is sampled only when 1.
REQ-008 cfg_load  input  1  latch pattern_in and len_in, and clear history.
REQ-009 pattern_in  input  PAT_W  target pattern; bit len-1 is the first bit received, bit 0 the last.
REQ-010 len_in  input  LEN_W  pattern length.
REQ-011 overlap_en  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
REQ-012 clear_count  input  1  synchronous clear of match_count.
REQ-013 seq_seen  output  1  registered one-cycle match pulse.
REQ-014 match_count  output  CNT_W  saturating count of matches.
REQ-015 cfg_err  output  1  registered; 1 while the latched length is illegal.

Function
REQ-016 Shadow registers pat_q and len_q SHALL load from pattern_in and len_in only on a cycle with cfg_load=1.
REQ-017 Legal lengths are 2..PAT_W; on any other len_q, cfg_err SHALL be 1 and no match SHALL ever be reported.
REQ-018 History register hist (PAT_W bits) SHALL update on inp_valid=1 with {hist[PAT_W-2:0], inp_bit}, the newest bit at bit 0.
REQ-019 Fill counter fill SHALL increment on each accepted bit and saturate at PAT_W.
REQ-020 A match SHALL occur on an accepted bit when next_fill >= len_q and the low len_q bits of next_hist equal the low len_q bits of pat_q.
REQ-021 seq_seen SHALL be 1 in the cycle after the edge that captured the completing bit, and 0 otherwise; latency 1 clock.
REQ-022 With inp_valid=0, hist, fill and match_count SHALL hold, and seq_seen SHALL be 0 next cycle.
REQ-023 Overlap mode: after a match, hist and fill SHALL continue unchanged.
REQ-024 Non-overlap mode: after a match, fill SHALL be 0, so the next match needs len_q fresh bits.
REQ-025 cfg_load SHALL clear hist and fill, discard any simultaneous inp_bit, and suppress a match that cycle.
REQ-026 match_count SHALL increment by 1 per match and saturate at all-ones with no wrap.
REQ-027 clear_count SHALL set match_count to 0; when it coincides with a match, clear wins (count = 0), but seq_seen still pulses.
REQ-028 The effective state machine is FILLING (fill < len_q) -> ARMED (fill >= len_q), returning to FILLING on cfg_load, on a non-overlap match, or on reset.

Reset
REQ-029 While reset=0: hist=0, fill=0, seq_seen=0, match_count=0, pat_q=0, len_q=0, cfg_err=1, applied asynchronously.
REQ-030 Reset deassertion SHALL be clean; the first accepted bit is the clock edge after reset rises, and reset mid-stream discards all partial progress.

Structure
REQ-031 Package seq_detect_pkg SHALL hold the PAT_W and CNT_W defaults, the LEN_W function and the minimum-length constant (2).
REQ-032 One sub-module, seq_match_cmp, SHALL be a combinational masked compare (hist, pat, len -> hit); all state stays in seq_detect_prog.

Verification
REQ-033 Config pattern 4'b1011, len 4, overlap_en=1; stream 1,0,1,1,0,1,1 -> seq_seen pulses after bits 4 and 7; match_count=2.
REQ-034 Same stream, overlap_en=0 -> a single pulse after bit 4; match_count=1.
REQ-035 Stream 1,0,1 with inp_valid=0 for 3 cycles, then 1 -> one pulse exactly one cycle after the final accepted bit; no pulse during the gap.
REQ-036 len_in=1 and len_in=PAT_W+1 -> cfg_err=1 and no pulses for 20 random bits; len_in=PAT_W with an all-ones pattern -> pulse after exactly PAT_W ones.
REQ-037 Drive reset=0 asynchronously after bits 1,0,1 -> outputs clear immediately; after release, bit 1 alone gives no match, and a full 1,0,1,1 is required.
REQ-038 CNT_W=2 with 5 matches -> match_count holds at 3; clear_count with a simultaneous match -> count 0 and seq_seen=1.
